serial_sub_ctrl: RTL

- Bit-serial WIDTH-bit unsigned subtractor controller.
- Accepts an operand pair (a, b) over a valid/ready handshake and steps a single 1-bit subtract cell LSB-first, one bit per cycle.
- Accumulates the difference and the final borrow, then presents the result over a valid/ready handshake.
- Trades area for latency wherever a full-width subtractor is not justified.

---
 rtl/serial_sub_pkg.sv | 18 +
 rtl/sub_bit_cell.sv | 22 ++
 rtl/serial_sub_ctrl.sv | 135 +++++++++++++
 3 files changed

// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding and
// the supported operand-width range.
package serial_sub_pkg;

    typedef logic [1:0] state_t;

    localparam state_t IDLE = 2'd0;
    localparam state_t RUN  = 2'd1;
    localparam state_t DONE = 2'd2;

    localparam int WIDTH_MIN = 2;
    localparam int WIDTH_MAX = 32;

    function automatic bit width_legal(input int w);
        return (w >= WIDTH_MIN) && (w <= WIDTH_MAX);
    endfunction

endpackage

// File: rtl/sub_bit_cell.sv
// One-bit full subtractor: two half-subtract stages, borrows merged by an OR.
module sub_bit_cell (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bout
);

    logic hs1_d;
    logic hs1_b;
    logic hs2_b;

    assign hs1_d = x ^ y;
    assign hs1_b = ~x & y;

    assign d     = hs1_d ^ bin;
    assign hs2_b = ~hs1_d & bin;

    assign bout  = hs1_b | hs2_b;

endmodule

// File: rtl/serial_sub_ctrl.sv
// Bit-serial WIDTH-bit unsigned subtractor with valid/ready on both sides.
// Define SERIAL_SUB_SAT_EN to clamp diff to 0 whenever the result borrows.
module serial_sub_ctrl
    import serial_sub_pkg::*;
#(
    parameter  int WIDTH = 8,
    localparam int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out,
    output logic             busy
);

    if (!width_legal(WIDTH)) begin : g_bad_width
        $error("serial_sub_ctrl: WIDTH must lie in 2..32");
    end

    state_t             state_q;
    state_t             state_d;
    logic [WIDTH-1:0]   sa_q;
    logic [WIDTH-1:0]   sb_q;
    logic [WIDTH-2:0]   res_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               bflop_q;
    logic [WIDTH-1:0]   diff_q;
    logic               borrow_q;

    logic               cell_d;
    logic               cell_bout;
    logic               run_last;
    logic [WIDTH-1:0]   res_ext;

    sub_bit_cell u_cell (
        .x    (sa_q[0]),
        .y    (sb_q[0]),
        .bin  (bflop_q),
        .d    (cell_d),
        .bout (cell_bout)
    );

    assign run_last = (state_q == RUN) && (cnt_q == CNT_W'(WIDTH - 1));

    // The LSB slot is only ever shifted out, so the accumulator keeps WIDTH-1
    // bits and the final cell output completes the word on the last step.
    assign res_ext  = {cell_d, res_q};

    // NOTE: clocked state uses non-blocking assignments so every flop samples
    // the pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every signal assigned in a combinational block gets a default
    // first, otherwise an unhandled path infers a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid)  state_d = RUN;
            RUN:     if (run_last)  state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default:                state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state_q)
            IDLE: in_ready = 1'b1;
            RUN:  busy     = 1'b1;
            DONE: begin
                out_valid = 1'b1;
                busy      = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sa_q     <= '0;
            sb_q     <= '0;
            res_q    <= '0;
            cnt_q    <= '0;
            bflop_q  <= 1'b0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        sa_q    <= a;
                        sb_q    <= b;
                        bflop_q <= 1'b0;
                        cnt_q   <= '0;
                    end
                end
                RUN: begin
                    sa_q    <= sa_q >> 1;
                    sb_q    <= sb_q >> 1;
                    res_q   <= res_ext[WIDTH-1:1];
                    bflop_q <= cell_bout;
                    if (run_last) begin
                        borrow_q <= cell_bout;
`ifdef SERIAL_SUB_SAT_EN
                        diff_q   <= cell_bout ? '0 : res_ext;
`else
                        diff_q   <= res_ext;
`endif
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign diff       = diff_q;
    assign borrow_out = borrow_q;

endmodule
